// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels over a big-endian byte array.
// The DMEM_ALIGN_CHECK_EN macro rejects misaligned word accesses; without it, word addresses are aligned down.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] BYTE_LAST = ADDR_W'(DEPTH_BYTES - 1);
  localparam logic [3:0]        CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              acc_err_q, acc_err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

  logic             commit;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      rd_word;

  // Range is judged on the raw request address, so aligning down can never hide an overrun.
  always_comb begin
    req_err = req_byte ? (req_addr > BYTE_LAST) : (req_addr > WORD_LAST);
    req_idx = req_addr[IDX_W-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    if (!req_byte && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
`else
    if (!req_byte) req_idx[1:0] = 2'b00;
`endif
  end

  assign commit  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign rd_word = {mem_q[addr_q], mem_q[addr_q + IDX_W'(1)],
                    mem_q[addr_q + IDX_W'(2)], mem_q[addr_q + IDX_W'(3)]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_err_d = acc_err_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          byte_d    = req_byte;
          addr_d    = req_idx;
          wdata_d   = req_wdata;
          acc_err_d = req_err;
          cnt_d     = CNT_LOAD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = acc_err_q;
          if (acc_err_q || write_q) rdata_d = 32'h0;
          else if (byte_q)          rdata_d = {24'h0, mem_q[addr_q]};
          else                      rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      byte_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      acc_err_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      acc_err_q <= acc_err_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Storage survives reset, but a reset on the commit edge must still suppress the store.
  always_ff @(posedge clk) begin
    if (rst && commit && write_q && !acc_err_q) begin
      if (byte_q) begin
        mem_q[addr_q] <= wdata_q[7:0];
      end else begin
        mem_q[addr_q]              <= wdata_q[31:24];
        mem_q[addr_q + IDX_W'(1)]  <= wdata_q[23:16];
        mem_q[addr_q + IDX_W'(2)]  <= wdata_q[15:8];
        mem_q[addr_q + IDX_W'(3)]  <= wdata_q[7:0];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of load/store vectors with hand-computed
// results, followed by hand-written back-pressure and reset corner-case sequences.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic        isWrite;
    logic        isByte;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vector_t;

  vector_t vecs[$];

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void addVec(input string name, input logic isWrite, input logic isByte,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr);
    vector_t v;
    v.name = name; v.isWrite = isWrite; v.isByte = isByte; v.addr = addr;
    v.wdata = wdata; v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endfunction

  // Called at a negedge just after an accept edge; returns edges until resp_valid is seen.
  task automatic waitResponse(output int edges);
    edges = 0;
    while (!resp_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // Runs one full transaction with resp_ready held high; called and returns at a negedge.
  task automatic applyStimulus(input vector_t v);
    int edges;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = v.isWrite;
    req_byte   = v.isByte;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    checkOutput({v.name, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waitResponse(edges);
    checkOutput({v.name, " latency"}, 32'(edges), 32'(LAT));
    checkOutput({v.name, " rdata"}, resp_rdata, v.expRdata);
    checkOutput({v.name, " err"}, 32'(resp_err), 32'(v.expErr));
    @(posedge clk);
    @(negedge clk);
    checkOutput({v.name, " valid after handshake"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int edges;
    vector_t v;

    addVec("st w 0x10",      1, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0);
    addVec("ld w 0x10",      0, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
    addVec("ld b 0x10",      0, 1, 32'h10,       32'h0,        32'h000000DE, 0);
    addVec("ld b 0x11",      0, 1, 32'h11,       32'h0,        32'h000000AD, 0);
    addVec("ld b 0x13",      0, 1, 32'h13,       32'h0,        32'h000000EF, 0);
    addVec("st b 0x12",      1, 1, 32'h12,       32'h00000055, 32'h0,        0);
    addVec("ld w 0x10 b",    0, 0, 32'h10,       32'h0,        32'hDEAD55EF, 0);
    addVec("ld w 0x3FC",     0, 0, 32'h3FC,      32'h0,        32'h0,        0);
    addVec("ld w 0x3FD",     0, 0, 32'h3FD,      32'h0,        32'h0,        1);
    addVec("st b 0x3FF",     1, 1, 32'h3FF,      32'h000000A5, 32'h0,        0);
    addVec("ld b 0x400",     0, 1, 32'h400,      32'h0,        32'h0,        1);
    addVec("ld b 0x3FF",     0, 1, 32'h3FF,      32'h0,        32'h000000A5, 0);
    addVec("st w 0x3FE",     1, 0, 32'h3FE,      32'hFFFFFFFF, 32'h0,        1);
    addVec("ld w 0x3FC b",   0, 0, 32'h3FC,      32'h0,        32'h000000A5, 0);
    addVec("ld b 0xFFFFFFFF",0, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        1);
`ifdef DMEM_ALIGN_CHECK_EN
    addVec("ld w 0x12 align",0, 0, 32'h12,       32'h0,        32'h0,        1);
`else
    addVec("ld w 0x12 align",0, 0, 32'h12,       32'h0,        32'hDEAD55EF, 0);
`endif
    addVec("st b 0x11",      1, 1, 32'h11,       32'hAABBCC77, 32'h0,        0);
    addVec("ld w 0x10 c",    0, 0, 32'h10,       32'h0,        32'hDE7755EF, 0);

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset rdata", resp_rdata, 32'h0);
    checkOutput("reset err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Back-pressure: response held for 5 cycles while a second request waits on the bus.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_addr   = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_byte = 1'b1;
    req_addr = 32'h13;
    waitResponse(edges);
    checkOutput("bp latency", 32'(edges), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp held valid", 32'(resp_valid), 32'd1);
      checkOutput("bp held rdata", resp_rdata, 32'hDE7755EF);
      checkOutput("bp req_ready low", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("bp still valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp valid after handshake", 32'(resp_valid), 32'd0);
    checkOutput("bp idle after handshake", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp second accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    waitResponse(edges);
    checkOutput("bp second latency", 32'(edges), 32'(LAT));
    checkOutput("bp second rdata", resp_rdata, 32'h000000EF);
    checkOutput("bp second err", 32'(resp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset lands on the commit edge of a store: no response, no write.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rst busy req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst busy no valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    v.name = "ld w 0x20 after rst"; v.isWrite = 0; v.isByte = 0; v.addr = 32'h20;
    v.wdata = 32'h0; v.expRdata = 32'h0; v.expErr = 0;
    applyStimulus(v);

    // Reset while a response is stalled drops it.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waitResponse(edges);
    checkOutput("rst resp latency", 32'(edges), 32'(LAT));
    checkOutput("rst resp rdata before", resp_rdata, 32'hDE7755EF);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rst resp valid dropped", 32'(resp_valid), 32'd0);
    checkOutput("rst resp rdata cleared", resp_rdata, 32'h0);
    checkOutput("rst resp req_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the datapath's data-memory interface.
- Serves load/store requests from the datapath's memory stage over a valid/ready request channel and a valid/ready response channel.
- Backing storage is a byte array, addressed big-endian in MIPS style.
- Models a multi-cycle memory with programmable latency so that stall logic in the datapath can be exercised.

Parameters:
- DEPTH_BYTES, 1024, size of the byte-addressed storage array.
- LATENCY, 2, number of BUSY cycles between request accept and response; legal range 1..15.
- ADDR_W, 32, width of the request address.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte stores use [7:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  access rejected (out of range or misaligned).

Behaviour:
- Reset (rst==0 at a rising edge):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Latency counter and request latches are cleared.
  - Storage is NOT cleared by reset. It is zero-initialised at time 0.
- FSM states are IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch write, byte, addr and wdata, load the counter with LATENCY-1, and go to BUSY.
  - req_ready is low in every other state.
- BUSY:
  - Counter decrements once per edge.
  - On the edge where the counter==0, the access commits and the state goes to RESP.
  - The store writes storage on that edge; the load samples storage on that edge.
- Response timing: resp_valid rises exactly LATENCY edges after the accept edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On an edge with resp_ready=1, go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - resp_ready=0 stalls indefinitely with outputs held.
- Throughput: one transaction per LATENCY+2 cycles when resp_ready is held at 1.
- Word access at address a:
  - Load: rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Store: writes wdata[31:24] to mem[a] through wdata[7:0] to mem[a+3].
- Byte access:
  - Load: rdata = {24'b0, mem[a]} (zero-extended).
  - Store: writes wdata[7:0] to mem[a] only.
- Range error: a word access with a > DEPTH_BYTES-4, or a byte access with a > DEPTH_BYTES-1.
  - resp_err=1, rdata=0, no storage write.
  - The check is done on the full ADDR_W bits; there is no wrap-around.
- Input stability: request inputs are ignored outside IDLE. Only the latched copy is used.
- Reset during BUSY:
  - The transaction is aborted and no storage write occurs.
  - If the commit edge coincides with rst==0, reset wins and no write occurs.
- Reset during RESP: the response is dropped and resp_valid=0 next cycle.
- Simultaneous edge with resp_ready=1 in RESP and req_valid=1: the request is not accepted on that edge. It is accepted on the following edge in IDLE.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a word access with req_addr[1:0] != 0 returns resp_err=1 and rdata=0, with no write. Range check still applies.
- Undefined: for word accesses, req_addr[1:0] is forced to 0 at latch time, so the access is aligned down and never errors for misalignment. Byte accesses are unaffected either way.

Test Plan:
1. Reset value and store/load, LATENCY=2:
   - Stimulus: rst=0 for 2 cycles, then rst=1. Word store addr 0x10, wdata 0xDEADBEEF with resp_ready=1. Then word load 0x10.
   - Response: resp_valid 2 edges after each accept; store resp_err=0, rdata=0; load rdata=0xDEADBEEF.
2. Endianness:
   - Stimulus: after test 1, byte loads at 0x10, 0x11 and 0x13.
   - Response: rdata 0x000000DE, 0x000000AD and 0x000000EF. Byte store 0x55 at 0x12, then word load 0x10 returns 0xDEAD55EF.
3. Range boundary:
   - Stimulus: word load 0x3FC, word load 0x3FD, byte store 0x3FF, byte load 0x400.
   - Response: resp_err = 0, 1, 0, 1; the 0x400 access returns rdata=0.
4. Back-pressure:
   - Stimulus: load 0x10 with resp_ready=0 for 5 cycles, req_valid held at 1 with a second request.
   - Response: resp_valid and rdata held 5 cycles, req_ready=0 throughout; the second request is accepted one edge after the resp handshake.
5. Reset mid-operation:
   - Stimulus: store 0x12345678 to 0x20, rst=0 on the commit edge.
   - Response: resp_valid never rises; a later load 0x20 returns 0x00000000.
6. Alignment:
   - Stimulus: word load 0x12 after test 2.
   - Response: with DMEM_ALIGN_CHECK_EN, resp_err=1 and rdata=0. Without it, rdata=0xDEAD55EF and resp_err=0.
